// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, parity modes and parity helpers for the UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Data narrower than 9 bits is zero-extended by the caller, which leaves the XOR unchanged
  function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

  // Mode 11 is reserved and behaves like no parity
  function automatic logic has_parity(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small power-of-two FIFO queuing words for the transmitter
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   push,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full     = count == (AW+1)'(DEPTH);
  assign empty    = count == '0;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage and pointers; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with input FIFO, runtime parity and stop-bit selection
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [1:0]                  parity_mode,
  input  logic                        two_stop,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [2:0]                  tx_state
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  state_t               state;
  logic [CW-1:0]        baud;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift, head;
  logic [1:0]           mode_r;
  logic                 two_r, stop2, par_r;
  logic                 full, empty, tick, pop;

  uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push_data (tx_data),
    .push      (tx_valid),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  assign tx_ready = !full;
  assign tick     = baud == CW'(CLKS_PER_BIT - 1);
  assign busy     = state != IDLE;
  assign tx_state = state;
  // A new frame starts from IDLE or straight out of the final stop bit, giving back-to-back frames
  assign pop      = !empty && (state == IDLE || (state == STOP && tick && (!two_r || stop2)));

  // Frame FSM: latches config at pop, shifts data LSB first, advances only on baud terminal count
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      mode_r  <= PAR_NONE;
      two_r   <= 1'b0;
      stop2   <= 1'b0;
      par_r   <= 1'b0;
    end else if (pop) begin
      state  <= START;
      tx     <= 1'b0;
      baud   <= '0;
      shift  <= head;
      mode_r <= parity_mode;
      two_r  <= two_stop;
      stop2  <= 1'b0;
      par_r  <= parity_bit(9'(head), parity_mode);
    end else if (state != IDLE) begin
      baud <= tick ? '0 : baud + 1'b1;
      if (tick) begin
        case (state)
          START: begin
            state   <= DATA;
            tx      <= shift[0];
            shift   <= shift >> 1;
            bit_idx <= '0;
          end
          DATA: begin
            if (bit_idx == IW'(DATA_BITS - 1)) begin
              state <= has_parity(mode_r) ? PARITY : STOP;
              tx    <= has_parity(mode_r) ? par_r : 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end
          PARITY: begin
            state <= STOP;
            tx    <= 1'b1;
          end
          STOP: begin
            if (two_r && !stop2) stop2 <= 1'b1;
            else state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed self-checking bench for the parametrised UART transmitter
module tb_uart_tx_param;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [1:0] parity_mode = 2'b00;
  logic       two_stop = 1'b0;
  logic       tx, busy;
  logic [2:0] fifo_count;
  logic [2:0] tx_state;

  logic [4:0] tx_data5 = '0;
  logic       tx_valid5 = 1'b0;
  logic       tx_ready5, tx5, busy5;
  logic [2:0] fifo_count5;
  logic [2:0] tx_state5;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int busy5_cnt = 0;
  logic wave  [0:8191];
  logic wave5 [0:8191];
  logic expv  [0:1023];
  int   exp_len = 0;

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .tx          (tx),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .tx_state    (tx_state)
  );

  uart_tx_param #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut5 (
    .clk         (clk),
    .n_rst       (n_rst),
    .tx_data     (tx_data5),
    .tx_valid    (tx_valid5),
    .tx_ready    (tx_ready5),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .tx          (tx5),
    .busy        (busy5),
    .fifo_count  (fifo_count5),
    .tx_state    (tx_state5)
  );

  always #5 clk = ~clk;

  // Log the serial lines and busy time once per cycle, away from the active edge
  always @(negedge clk) begin
    if (cyc < 8192) begin
      wave[cyc]  = tx;
      wave5[cyc] = tx5;
    end
    if (busy) busy_cnt++;
    if (busy5) busy5_cnt++;
    cyc++;
  end

  function automatic void push_bit(input logic b);
    for (int k = 0; k < CPB; k++) begin
      expv[exp_len] = b;
      exp_len++;
    end
  endfunction

  function automatic void add_frame(input logic [8:0] d, input int nb, input logic [1:0] pm, input logic ts);
    logic p;
    p = 1'b0;
    push_bit(1'b0);
    for (int i = 0; i < nb; i++) begin
      push_bit(d[i]);
      p = p ^ d[i];
    end
    if (pm == 2'b01) push_bit(p);
    if (pm == 2'b10) push_bit(~p);
    push_bit(1'b1);
    if (ts) push_bit(1'b1);
  endfunction

  function automatic int first_diff(input int s, input bit five);
    logic got;
    for (int i = 0; i < exp_len; i++) begin
      got = five ? wave5[s+i] : wave[s+i];
      if (got !== expv[i]) return i;
    end
    return -1;
  endfunction

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic push5(input logic [4:0] d);
    @(negedge clk);
    tx_valid5 = 1'b1;
    tx_data5  = d;
    @(posedge clk);
    #1 tx_valid5 = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (tx_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", tx_state); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", tx_ready); end
    checks++; if (tx5 !== 1'b1) begin errors++; $display("FAIL reset_tx5 got %b want 1", tx5); end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int s, b, d;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    push(8'hA5);
    s = cyc;
    b = busy_cnt;
    exp_len = 0;
    add_frame(9'h0A5, 8, 2'b00, 1'b0);
    repeat (50) @(negedge clk);
    #1;
    d = first_diff(s + 1, 1'b0);
    checks++; if (wave[s] !== 1'b1) begin errors++; $display("FAIL basic_no_early_start got %b want 1", wave[s]); end
    checks++; if (wave[s+1] !== 1'b0) begin errors++; $display("FAIL basic_latency got %b want 0", wave[s+1]); end
    checks++; if (d != -1) begin errors++; $display("FAIL basic_wave first bad sample %0d got %b want %b", d, wave[s+1+d], expv[d]); end
    checks++; if (busy_cnt - b != 40) begin errors++; $display("FAIL basic_busy_cycles got %0d want 40", busy_cnt - b); end
    checks++; if (wave[s+41] !== 1'b1) begin errors++; $display("FAIL basic_idle_after got %b want 1", wave[s+41]); end
    checks++; if (tx_state !== 3'd0) begin errors++; $display("FAIL basic_end_state got %0d want 0", tx_state); end
  endtask

  task automatic test_parity();
    int s, b, d;
    logic want;
    for (int m = 1; m <= 2; m++) begin
      parity_mode = 2'(m);
      two_stop    = 1'b1;
      want        = (m == 1) ? 1'b1 : 1'b0;
      push(8'h07);
      s = cyc;
      b = busy_cnt;
      exp_len = 0;
      add_frame(9'h007, 8, 2'(m), 1'b1);
      repeat (60) @(negedge clk);
      #1;
      d = first_diff(s + 1, 1'b0);
      checks++; if (wave[s+1+CPB*9] !== want) begin errors++; $display("FAIL parity_bit mode %0d got %b want %b", m, wave[s+1+CPB*9], want); end
      checks++; if (d != -1) begin errors++; $display("FAIL parity_wave mode %0d first bad sample %0d got %b want %b", m, d, wave[s+1+d], expv[d]); end
      checks++; if (busy_cnt - b != 48) begin errors++; $display("FAIL parity_frame_len mode %0d got %0d want 48", m, busy_cnt - b); end
    end
    parity_mode = 2'b00;
    two_stop    = 1'b0;
  endtask

  task automatic test_back_to_back();
    int s, b, d, hi;
    logic [7:0] bytes [5];
    bytes = '{8'h3C, 8'h81, 8'hF0, 8'h0F, 8'h55};
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    exp_len = 0;
    push(bytes[0]);
    s = cyc;
    b = busy_cnt;
    for (int i = 1; i < 5; i++) push(bytes[i]);
    @(negedge clk);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got %b want 0", tx_ready); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_count_full got %0d want 4", fifo_count); end
    push(8'hAA);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_drop_count got %0d want 4", fifo_count); end
    for (int i = 0; i < 5; i++) add_frame({1'b0, bytes[i]}, 8, 2'b00, 1'b0);
    repeat (245) @(negedge clk);
    #1;
    d = first_diff(s + 1, 1'b0);
    hi = 0;
    for (int i = 201; i <= 240; i++) if (wave[s+i] === 1'b1) hi++;
    checks++; if (d != -1) begin errors++; $display("FAIL b2b_wave first bad sample %0d got %b want %b", d, wave[s+1+d], expv[d]); end
    checks++; if (busy_cnt - b != 200) begin errors++; $display("FAIL b2b_contiguous busy cycles got %0d want 200", busy_cnt - b); end
    checks++; if (hi != 40) begin errors++; $display("FAIL b2b_dropped_byte idle-high samples got %0d want 40", hi); end
  endtask

  task automatic test_config_change();
    int s, d;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    exp_len = 0;
    push(8'hC3);
    s = cyc;
    push(8'h5A);
    repeat (12) @(negedge clk);
    parity_mode = 2'b10;
    add_frame(9'h0C3, 8, 2'b00, 1'b0);
    add_frame(9'h05A, 8, 2'b10, 1'b0);
    repeat (95) @(negedge clk);
    #1;
    d = first_diff(s + 1, 1'b0);
    checks++; if (d != -1) begin errors++; $display("FAIL cfg_change_wave first bad sample %0d got %b want %b", d, wave[s+1+d], expv[d]); end
    checks++; if (wave[s+1+40+CPB*9] !== 1'b1) begin errors++; $display("FAIL cfg_change_next_parity got %b want 1", wave[s+1+40+CPB*9]); end
    parity_mode = 2'b00;
  endtask

  task automatic test_data_bits5();
    int s, b, d;
    parity_mode = 2'b01;
    two_stop    = 1'b0;
    exp_len = 0;
    push5(5'h1F);
    s = cyc;
    b = busy5_cnt;
    add_frame(9'h01F, 5, 2'b01, 1'b0);
    repeat (40) @(negedge clk);
    #1;
    d = first_diff(s + 1, 1'b1);
    checks++; if (wave5[s+1] !== 1'b0) begin errors++; $display("FAIL d5_start got %b want 0", wave5[s+1]); end
    checks++; if (d != -1) begin errors++; $display("FAIL d5_wave first bad sample %0d got %b want %b", d, wave5[s+1+d], expv[d]); end
    checks++; if (wave5[s+1+CPB*6] !== 1'b1) begin errors++; $display("FAIL d5_parity got %b want 1", wave5[s+1+CPB*6]); end
    checks++; if (busy5_cnt - b != 32) begin errors++; $display("FAIL d5_frame_len got %0d want 32", busy5_cnt - b); end
    parity_mode = 2'b00;
  endtask

  task automatic test_reset_mid();
    int s, b, hi;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    push(8'h00);
    push(8'h11);
    push(8'h22);
    repeat (6) @(negedge clk);
    checks++; if (tx_state !== 3'd2 || tx !== 1'b0) begin errors++; $display("FAIL rst_mid_precondition state %0d tx %b want 2 0", tx_state, tx); end
    #2 n_rst = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_mid_tx got %b want 1", tx); end
    checks++; if (tx_state !== 3'd0) begin errors++; $display("FAIL rst_mid_state got %0d want 0", tx_state); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_mid_count got %0d want 0", fifo_count); end
    checks++; if (busy !== 1'b0 || tx_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_flags busy %b ready %b want 0 1", busy, tx_ready); end
    @(negedge clk);
    n_rst = 1'b1;
    s = cyc;
    b = busy_cnt;
    repeat (60) @(negedge clk);
    #1;
    hi = 0;
    for (int i = 0; i < 60; i++) if (wave[s+i] === 1'b1) hi++;
    checks++; if (hi != 60) begin errors++; $display("FAIL rst_mid_quiet high samples got %0d want 60", hi); end
    checks++; if (busy_cnt - b != 0) begin errors++; $display("FAIL rst_mid_no_frame busy cycles got %0d want 0", busy_cnt - b); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_config_change();
    test_data_bits5();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
